// File: rtl/mem_init_pkg.sv
// Shared types for the memory read-modify-write initiator:
// client opcodes and sequencer states.
package mem_init_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_rmw_initiator.sv
// Single-port memory initiator: READ, WRITE and ADD read-modify-write,
// one operation in flight, one response per request.
module mem_rmw_initiator
  import mem_init_pkg::*;
#(
  parameter int ASIZE = 8,
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ASIZE-1:0] req_addr,
  input  logic [DSIZE-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DSIZE-1:0] rsp_data,
  output logic             rsp_err,
  output logic             rsp_ovf,
  output logic             mem_we,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata
);

  state_e           state_q;
  op_e              op_q;
  logic [DSIZE-1:0] data_q;
  logic [ASIZE-1:0] maddr_q;
  logic [DSIZE-1:0] wdata_q;
  logic [DSIZE-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             rsp_ovf_q;
  logic [DSIZE:0]   sum;

  assign sum = {1'b0, mem_rdata} + {1'b0, data_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      data_q     <= '0;
      maddr_q    <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            data_q    <= req_data;
            rsp_err_q <= 1'b0;
            rsp_ovf_q <= 1'b0;
            unique case (op_e'(req_op))
              OP_READ, OP_ADD: begin
                maddr_q <= req_addr;
                state_q <= RD;
              end
              OP_WRITE: begin
                maddr_q    <= req_addr;
                wdata_q    <= req_data;
                rsp_data_q <= req_data;
                state_q    <= WR;
              end
              default: begin
                // reserved op: reject without touching memory
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
                state_q    <= RSP;
              end
            endcase
          end
        end
        RD: begin
          if (op_q == OP_ADD) begin
            wdata_q    <= sum[DSIZE-1:0];
            rsp_data_q <= sum[DSIZE-1:0];
            rsp_ovf_q  <= sum[DSIZE];
            state_q    <= WR;
          end else begin
            rsp_data_q <= mem_rdata;
            state_q    <= RSP;
          end
        end
        WR: state_q <= RSP;
        RSP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // reset masks the write strobe so an aborted WR never commits
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RSP) && !rst;
  assign mem_we    = (state_q == WR) && !rst;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_mem_rmw_initiator.sv
// Directed scoreboard bench for mem_rmw_initiator with a
// behavioural combinational-read memory.
module tb_mem_rmw_initiator;

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       o;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_ovf;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  exp_t       sb [$];
  int         checks;
  int         errors;

  mem_rmw_initiator #(.ASIZE(8), .DSIZE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ovf   (rsp_ovf),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] d, input int stall);
    exp_t       e;
    exp_t       x;
    int         lat;
    int         c;
    int         we_c;
    int         we_exp;
    logic [7:0] we_a;
    logic [7:0] we_d;
    logic [7:0] exp_w;
    logic [8:0] s;
    e.d = 8'h00; e.e = 1'b0; e.o = 1'b0;
    exp_w = 8'h00; lat = 1; we_exp = 0;
    we_a = 8'h00; we_d = 8'h00;
    case (op)
      2'b00: begin e.d = ref_mem[a]; lat = 2; end
      2'b01: begin
        e.d = d; ref_mem[a] = d; lat = 2;
        exp_w = d; we_exp = 1;
      end
      2'b10: begin
        s = {1'b0, ref_mem[a]} + {1'b0, d};
        e.d = s[7:0]; e.o = s[8]; ref_mem[a] = s[7:0];
        lat = 3; exp_w = s[7:0]; we_exp = 2;
      end
      default: begin e.e = 1'b1; lat = 1; end
    endcase
    sb.push_back(e);
    rsp_ready = (stall == 0);
    chk("req_ready_pre", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom);
    req_addr = 8'($urandom);
    req_data = 8'($urandom);
    c = 1; we_c = 0;
    while (!rsp_valid && c < 10) begin
      if (mem_we) begin
        we_c = c; we_a = mem_addr; we_d = mem_wdata;
      end
      @(negedge clk);
      c++;
    end
    chk("latency", 32'(c), 32'(lat));
    chk("we_cycle", 32'(we_c), 32'(we_exp));
    if (we_c != 0) begin
      chk("we_addr", 32'(we_a), 32'(a));
      chk("we_data", 32'(we_d), 32'(exp_w));
    end
    for (int i = 0; i < stall; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(e.d));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    x = sb.pop_front();
    chk("rsp_data", 32'(rsp_data), 32'(x.d));
    chk("rsp_err", 32'(rsp_err), 32'(x.e));
    chk("rsp_ovf", 32'(rsp_ovf), 32'(x.o));
    @(negedge clk);
    chk("req_ready_post", 32'(req_ready), 32'd1);
    chk("rsp_valid_post", 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_addr = 8'h00; req_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    #1;
    chk("req_ready_after_reset", 32'(req_ready), 32'd1);
    @(negedge clk);

    run_op(2'b01, 8'h10, 8'hA5, 0);
    run_op(2'b01, 8'h10, 8'h3C, 0);
    run_op(2'b00, 8'h10, 8'h00, 0);
    run_op(2'b01, 8'h20, 8'hFF, 0);
    run_op(2'b10, 8'h20, 8'h01, 0);
    run_op(2'b00, 8'h20, 8'h00, 0);
    chk("mem_20", 32'(mem[8'h20]), 32'h00);
    run_op(2'b01, 8'h21, 8'h40, 0);
    run_op(2'b10, 8'h21, 8'h17, 0);
    run_op(2'b11, 8'h55, 8'h99, 0);
    run_op(2'b00, 8'h21, 8'h00, 5);
    run_op(2'b10, 8'h10, 8'h0F, 2);

    // ADD aborted by reset during its write cycle
    run_op(2'b01, 8'h30, 8'h55, 0);
    req_valid = 1'b1; req_op = 2'b10;
    req_addr = 8'h30; req_data = 8'h11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rd_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("abort_wr_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we_masked", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk_reset_vals("abort");
    rst = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("abort_mem_kept", 32'(mem[8'h30]), 32'h55);
    run_op(2'b00, 8'h30, 8'h00, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rmw_initiator.md
# mem_rmw_initiator

Memory-side initiator that turns single client requests (READ, WRITE, ADD read-modify-write) into cycles on a single-port memory interface of the `we/addr/mem_in/mem_out` style. The memory read path is combinational: data for the presented address is valid in the same cycle. The block sits between a client issuing valid/ready requests and the memory (real or abstracted). It sequences one operation at a time and returns a single response per request over a valid/ready channel.

## Interface
- `ASIZE`, default 8: address width.
- `DSIZE`, default 8: data width.

- `clk` in 1: single clock, all flops on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 2: 00 READ, 01 WRITE, 10 ADD, 11 reserved.
- `req_addr` in ASIZE: target address.
- `req_data` in DSIZE: write data (WRITE) or addend (ADD).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: client accepts response.
- `rsp_data` out DSIZE: result data.
- `rsp_err` out 1: reserved opcode was rejected.
- `rsp_ovf` out 1: ADD carry-out occurred.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ASIZE: memory address.
- `mem_wdata` out DSIZE: memory write data, driving the memory's `mem_in`.
- `mem_rdata` in DSIZE: memory read data, from the memory's `mem_out`.

## Operation
- FSM states: IDLE, RD, WR, RSP. Only one operation is in flight at a time.
- `req_ready` = (state==IDLE) && !rst. A request is accepted when `req_valid && req_ready`; op, addr and data are latched.
- Transitions out of IDLE on accept: READ→RD, ADD→RD, WRITE→WR, reserved→RSP.
- RD: `mem_we`=0 and `mem_addr`=addr_q. `mem_rdata` is captured at the end of the cycle.
  - READ→RSP with rsp_data = captured value.
  - ADD→WR with wdata_q = rdata + data_q, truncated to DSIZE bits, carry dropped; the carry is stored as ovf.
- WR: `mem_we`=1, `mem_addr`=addr_q, `mem_wdata`=wdata_q. Next state is RSP.
  - For WRITE, wdata_q = req_data and rsp_data = req_data.
  - For ADD, rsp_data = the sum.
- RSP: `rsp_valid`=1. `rsp_data`, `rsp_err` and `rsp_ovf` are held stable until `rsp_ready`, then the FSM returns to IDLE.
  - `rsp_err`=1 only for a reserved opcode; `rsp_data`=0 in that case.
  - `rsp_ovf`=1 only for an ADD with carry.
- Memory outputs are decoded from registered state only. There is no combinational path from `req_*` or `rsp_ready` to `mem_*`.
- Outside RD/WR: `mem_we`=0, and `mem_addr`/`mem_wdata` hold their last values.

## Timing
- Accept in cycle N:
  - READ: RD at N+1, `rsp_valid` at N+2.
  - WRITE: WR (write committed) at N+1, `rsp_valid` at N+2.
  - ADD: RD at N+1, WR at N+2, `rsp_valid` at N+3.
  - Reserved: `rsp_valid` at N+1, and the memory is untouched.
- With `rsp_ready` held high, back-to-back READs run one per 3 cycles, because IDLE is revisited for one cycle.
- Response backpressure: RSP is held indefinitely, `req_ready` stays 0, and no memory activity occurs.
- Reset values:
  - state IDLE
  - `req_ready` 0 while rst=1, 1 the cycle after
  - `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `rsp_ovf` 0
  - `mem_we` 0, `mem_addr` 0, `mem_wdata` 0
- Reset mid-operation:
  - If rst=1 in a WR cycle, `mem_we` is forced to 0 and no write is performed.
  - In-flight operations are dropped with no response.
  - A pending response is discarded.
- `req_valid` while not ready is ignored. The request must be held by the client per valid/ready rules.
- ADD wrap-around: 8'hFF + 8'h01 writes 8'h00 and sets `rsp_ovf`=1.

## Structure
- Package `mem_init_pkg`:
  - `op_e` enum (READ, WRITE, ADD, RSVD; 2-bit)
  - `state_e` enum (IDLE, RD, WR, RSP)
- Single module, no sub-modules. The adder is inline, with a DSIZE+1-bit sum whose MSB gives ovf.

## Test plan
- Reset, then WRITE addr 8'h10 data 8'hA5 → `mem_we`=1, `mem_addr`=8'h10, `mem_wdata`=8'hA5 at N+1; `rsp_valid` at N+2 with `rsp_data`=8'hA5, `rsp_err`=0.
- WRITE 8'h10=8'h3C, then READ 8'h10 → READ response `rsp_data`=8'h3C, 2 cycles after its accept.
- Memory 8'h20=8'hFF, ADD 8'h20 with 8'h01 → write 8'h00 at N+2; response at N+3 with `rsp_data`=8'h00, `rsp_ovf`=1. A following READ 8'h20 returns 8'h00.
- Reserved op 2'b11 → `rsp_valid` at N+1, `rsp_err`=1, `rsp_data`=0, no `mem_we` pulse.
- READ with `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_data` stable, `req_ready`=0 and `mem_we`=0 throughout. The response completes on the first `rsp_ready`=1 cycle, and `req_ready`=1 the next cycle.
- ADD accepted, rst asserted in the WR cycle → no write (the memory location keeps its old value), no response, and the outputs show their reset values the cycle after.
